// File: rtl/seq_frame_ctrl_if.sv
// Host-side bundle for seq_frame_ctrl: configuration, run control, serial data and results.
// Optional cfg_mask is present only when SEQ_FRAME_CTRL_MASK_EN is defined.
interface seq_frame_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
`ifdef SEQ_FRAME_CTRL_MASK_EN
    logic [MAX_LEN-1:0] cfg_mask;
`endif
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_frames;
    logic               start;
    logic               abort;
    logic               data;
    logic               busy;
    logic               match;
    logic               not_match;
    logic               done;
    logic [CNT_W-1:0]   match_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    modport master (
`ifdef SEQ_FRAME_CTRL_MASK_EN
        output cfg_mask,
`endif
        output cfg_we, cfg_pattern, cfg_len, cfg_frames, start, abort, data,
        input  busy, match, not_match, done, match_cnt, miss_cnt
    );

    modport slave (
`ifdef SEQ_FRAME_CTRL_MASK_EN
        input  cfg_mask,
`endif
        input  cfg_we, cfg_pattern, cfg_len, cfg_frames, start, abort, data,
        output busy, match, not_match, done, match_cnt, miss_cnt
    );
endinterface

// File: rtl/seq_frame_ctrl.sv
// Non-overlapping serial frame checker with run control, saturating hit/miss counters
// and frame budget. Define SEQ_FRAME_CTRL_MASK_EN to add per-bit don't-care masking.
module seq_frame_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_frame_ctrl_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] ign;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   frames_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic [CNT_W-1:0]   miss_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;
    logic               busy_q;
    logic               match_q;
    logic               not_match_q;
    logic               done_q;

    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   pos;
    logic               bit_err;
    logic               frame_err;
    logic               last_bit;
    logic               budget_hit;
    logic [CNT_W-1:0]   frame_cnt_d;
    logic [CNT_W-1:0]   match_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Out-of-range lengths are folded once at write time so the run logic never sees them.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_W'(1);
        if (l > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        return l;
    endfunction

`ifdef SEQ_FRAME_CTRL_MASK_EN
    logic [MAX_LEN-1:0] ign_q;
    assign ign = ign_q;
`else
    assign ign = '0;
`endif

    always_comb begin
        last_idx    = IDX_W'(len_q - LEN_W'(1));
        pos         = last_idx - idx_q;
        bit_err     = (bus.data ^ pat_q[pos]) & ~ign[pos];
        frame_err   = err_q | bit_err;
        last_bit    = (idx_q == last_idx);
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        budget_hit  = (frames_q != '0) && (frame_cnt_d == frames_q);
        match_cnt_d = sat_inc(match_cnt_q);
        miss_cnt_d  = sat_inc(miss_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
`ifdef SEQ_FRAME_CTRL_MASK_EN
            ign_q       <= '0;
`endif
            len_q       <= LEN_W'(1);
            frames_q    <= '0;
            frame_cnt_q <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            match_q     <= 1'b0;
            not_match_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            match_q     <= 1'b0;
            not_match_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cfg_we) begin
                        pat_q    <= bus.cfg_pattern;
`ifdef SEQ_FRAME_CTRL_MASK_EN
                        ign_q    <= bus.cfg_mask;
`endif
                        len_q    <= norm_len(bus.cfg_len);
                        frames_q <= bus.cfg_frames;
                    end
                    if (bus.start && !bus.abort) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                        frame_cnt_q <= '0;
                        match_cnt_q <= '0;
                        miss_cnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    // Abort dominates a verdict landing on the same edge.
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_bit) begin
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                        frame_cnt_q <= frame_cnt_d;
                        if (frame_err) begin
                            not_match_q <= 1'b1;
                            miss_cnt_q  <= miss_cnt_d;
                        end else begin
                            match_q     <= 1'b1;
                            match_cnt_q <= match_cnt_d;
                        end
                        if (budget_hit) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                        err_q <= frame_err;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.match     = match_q;
    assign bus.not_match = not_match_q;
    assign bus.done      = done_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
endmodule
